// File: rtl/easyaxi_pkg.sv
// Shared AXI widths, burst encodings and the AR channel payload type.
package easyaxi_pkg;

    localparam int unsigned AXI_ID_WIDTH    = 4;
    localparam int unsigned AXI_ADDR_WIDTH  = 32;
    localparam int unsigned AXI_LEN_WIDTH   = 8;
    localparam int unsigned AXI_SIZE_WIDTH  = 3;
    localparam int unsigned AXI_BURST_WIDTH = 2;

    localparam logic [AXI_BURST_WIDTH-1:0] BURST_FIXED = 2'b00;
    localparam logic [AXI_BURST_WIDTH-1:0] BURST_INCR  = 2'b01;
    localparam logic [AXI_BURST_WIDTH-1:0] BURST_WRAP  = 2'b10;

    typedef struct packed {
        logic [AXI_ID_WIDTH-1:0]    id;
        logic [AXI_ADDR_WIDTH-1:0]  addr;
        logic [AXI_LEN_WIDTH-1:0]   len;
        logic [AXI_SIZE_WIDTH-1:0]  size;
        logic [AXI_BURST_WIDTH-1:0] burst;
    } ar_chan_t;

    // Flat payload width for an AR beat with the given field widths.
    function automatic int unsigned ar_payload_width(input int unsigned id_w,
                                                     input int unsigned addr_w,
                                                     input int unsigned len_w);
        return id_w + addr_w + len_w + AXI_SIZE_WIDTH + AXI_BURST_WIDTH;
    endfunction

endpackage

// File: rtl/easyaxi_sync_fifo.sv
// Generic synchronous FIFO with registered full/empty flags and level.
// No input reaches any handshake output combinationally.
module easyaxi_sync_fifo #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       wr_valid_i,
    output logic                       wr_ready_o,
    input  logic [WIDTH-1:0]           wr_data_i,
    output logic                       rd_valid_o,
    input  logic                       rd_ready_i,
    output logic [WIDTH-1:0]           rd_data_o,
    output logic [$clog2(DEPTH):0]     level_o
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned LVL_W = PTR_W + 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [LVL_W-1:0] level_q, level_d;
    logic             full_q, full_d;
    logic             empty_q, empty_d;
    logic             push, pop;

    // Handshakes, pointer advance, level update and flag lookahead.
    always_comb begin
        push     = wr_valid_i & ~full_q;
        pop      = rd_ready_i & ~empty_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        level_d  = level_q;
        if (push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
        if (pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
        case ({push, pop})
            2'b10:   level_d = level_q + LVL_W'(1);
            2'b01:   level_d = level_q - LVL_W'(1);
            default: level_d = level_q;
        endcase
        full_d  = (level_d == LVL_W'(DEPTH));
        empty_d = (level_d == '0);
    end

    // Control state registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
            full_q   <= 1'b0;
            empty_q  <= 1'b1;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            level_q  <= level_d;
            full_q   <= full_d;
            empty_q  <= empty_d;
        end
    end

    // Entry storage; cleared on reset so the idle head reads as zero.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else if (push) begin
            mem_q[wr_ptr_q] <= wr_data_i;
        end
    end

    assign wr_ready_o = ~full_q;
    assign rd_valid_o = ~empty_q;
    assign rd_data_o  = mem_q[rd_ptr_q];
    assign level_o    = level_q;

endmodule

// File: rtl/easyaxi_ar_buf.sv
// AXI AR channel buffer: FIFO decoupling plus an upstream stability monitor.
module easyaxi_ar_buf
    import easyaxi_pkg::*;
#(
    parameter int unsigned DEPTH  = 4,
    parameter int unsigned ID_W   = AXI_ID_WIDTH,
    parameter int unsigned ADDR_W = AXI_ADDR_WIDTH,
    parameter int unsigned LEN_W  = AXI_LEN_WIDTH
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    s_arvalid,
    output logic                    s_arready,
    input  logic [ID_W-1:0]         s_arid,
    input  logic [ADDR_W-1:0]       s_araddr,
    input  logic [LEN_W-1:0]        s_arlen,
    input  logic [2:0]              s_arsize,
    input  logic [1:0]              s_arburst,
    output logic                    m_arvalid,
    input  logic                    m_arready,
    output logic [ID_W-1:0]         m_arid,
    output logic [ADDR_W-1:0]       m_araddr,
    output logic [LEN_W-1:0]        m_arlen,
    output logic [2:0]              m_arsize,
    output logic [1:0]              m_arburst,
    output logic [$clog2(DEPTH):0]  level,
    output logic                    err_stable
);

    localparam int unsigned PAY_W = ar_payload_width(ID_W, ADDR_W, LEN_W);

    logic [PAY_W-1:0] s_pay;
    logic [PAY_W-1:0] m_pay;
    logic [PAY_W-1:0] cap_q;
    logic             pend_q, pend_d;
    logic             err_q, err_d;

    assign s_pay = {s_arid, s_araddr, s_arlen, s_arsize, s_arburst};

    easyaxi_sync_fifo #(
        .WIDTH (PAY_W),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk        (clk),
        .rst        (rst),
        .wr_valid_i (s_arvalid),
        .wr_ready_o (s_arready),
        .wr_data_i  (s_pay),
        .rd_valid_o (m_arvalid),
        .rd_ready_i (m_arready),
        .rd_data_o  (m_pay),
        .level_o    (level)
    );

    assign {m_arid, m_araddr, m_arlen, m_arsize, m_arburst} = m_pay;

    // A stalled valid must stay asserted with an unchanged payload next cycle.
    always_comb begin
        pend_d = s_arvalid & ~s_arready;
        err_d  = err_q;
        if (pend_q && (!s_arvalid || (s_pay != cap_q))) begin
            err_d = 1'b1;
        end
    end

    // Monitor state; the error flag is sticky until reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pend_q <= 1'b0;
            cap_q  <= '0;
            err_q  <= 1'b0;
        end else begin
            pend_q <= pend_d;
            cap_q  <= s_pay;
            err_q  <= err_d;
        end
    end

    assign err_stable = err_q;

endmodule

// File: tb/tb_easyaxi_ar_buf.sv
// Directed-plus-random bench for easyaxi_ar_buf against a queue model.
module tb_easyaxi_ar_buf;
    import easyaxi_pkg::*;

    localparam int unsigned DEPTH = 4;

    logic       clk;
    logic       rst;
    logic       v;
    logic       rdy;
    ar_chan_t   drv;
    logic       s_arready;
    logic       m_arvalid;
    logic [3:0] m_arid;
    logic [31:0] m_araddr;
    logic [7:0] m_arlen;
    logic [2:0] m_arsize;
    logic [1:0] m_arburst;
    logic [2:0] level;
    logic       err_stable;

    int vectors = 0;
    int miscompares = 0;

    // Reference model state
    ar_chan_t mq[$];
    bit       pend_m;
    bit       err_m;
    ar_chan_t cap_m;

    easyaxi_ar_buf #(.DEPTH(DEPTH), .ID_W(4), .ADDR_W(32), .LEN_W(8)) dut (
        .clk        (clk),
        .rst        (rst),
        .s_arvalid  (v),
        .s_arready  (s_arready),
        .s_arid     (drv.id),
        .s_araddr   (drv.addr),
        .s_arlen    (drv.len),
        .s_arsize   (drv.size),
        .s_arburst  (drv.burst),
        .m_arvalid  (m_arvalid),
        .m_arready  (rdy),
        .m_arid     (m_arid),
        .m_araddr   (m_araddr),
        .m_arlen    (m_arlen),
        .m_arsize   (m_arsize),
        .m_arburst  (m_arburst),
        .level      (level),
        .err_stable (err_stable)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_all(input string tag);
        chk({tag, "_level"}, 64'(level), 64'(mq.size()));
        chk({tag, "_s_arready"}, 64'(s_arready), 64'(mq.size() < DEPTH));
        chk({tag, "_m_arvalid"}, 64'(m_arvalid), 64'(mq.size() > 0));
        chk({tag, "_err_stable"}, 64'(err_stable), 64'(err_m));
        if (mq.size() > 0)
            chk({tag, "_head"}, 64'({m_arid, m_araddr, m_arlen, m_arsize, m_arburst}), 64'(mq[0]));
    endtask

    // One clock: predict from pre-edge inputs and model state, then compare.
    task automatic cycle(input string tag);
        bit       push, pop;
        bit       vin;
        ar_chan_t cur;
        vin  = v;
        cur  = drv;
        push = vin && (mq.size() < DEPTH);
        pop  = rdy && (mq.size() > 0);
        @(posedge clk);
        #1;
        if (pend_m && (!vin || cur != cap_m)) err_m = 1'b1;
        pend_m = vin && !push;
        cap_m  = cur;
        if (pop)  void'(mq.pop_front());
        if (push) mq.push_back(cur);
        check_all(tag);
    endtask

    function automatic ar_chan_t rand_pay();
        ar_chan_t p;
        p.id    = AXI_ID_WIDTH'($urandom);
        p.addr  = AXI_ADDR_WIDTH'($urandom);
        p.len   = AXI_LEN_WIDTH'($urandom);
        p.size  = AXI_SIZE_WIDTH'($urandom);
        p.burst = AXI_BURST_WIDTH'($urandom);
        return p;
    endfunction

    // Present a beat and hold it unchanged until the model says it is taken.
    task automatic push_one(input ar_chan_t p, input string tag);
        bit acc;
        acc = 1'b0;
        v   = 1'b1;
        drv = p;
        for (int k = 0; k < 16 && !acc; k++) begin
            acc = (mq.size() < DEPTH);
            cycle(tag);
        end
        chk({tag, "_accept_timeout"}, 64'(acc), 64'd1);
        v = 1'b0;
    endtask

    // Asynchronous reset pulse starting between clock edges.
    task automatic do_reset(input string tag);
        v   = 1'b0;
        rdy = 1'b0;
        rst = 1'b1;
        #1;
        mq.delete();
        pend_m = 1'b0;
        err_m  = 1'b0;
        cap_m  = '0;
        check_all(tag);
        chk({tag, "_m_araddr"}, 64'(m_araddr), 64'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    initial begin
        ar_chan_t p;
        rst = 1'b1;
        v   = 1'b0;
        rdy = 1'b0;
        drv = '0;
        mq.delete();
        pend_m = 1'b0;
        err_m  = 1'b0;
        cap_m  = '0;
        repeat (2) @(posedge clk);
        #1;
        check_all("reset");
        chk("reset_payload", 64'({m_arid, m_araddr, m_arlen, m_arsize, m_arburst}), 64'd0);
        rst = 1'b0;

        // Single transfer with 1-cycle latency
        rdy = 1'b1;
        p = '{id: 4'd3, addr: 32'h1000, len: 8'd7, size: 3'd2, burst: BURST_INCR};
        v = 1'b1; drv = p;
        cycle("single_c1");
        chk("single_addr", 64'(m_araddr), 64'h1000);
        v = 1'b0;
        cycle("single_c2");
        chk("single_level0", 64'(level), 64'd0);

        // Fill to full, fifth beat stalls, then drain in order
        rdy = 1'b0;
        for (int i = 0; i < 4; i++) begin
            p = rand_pay();
            p.addr = 32'(i * 32'h40);
            push_one(p, "fill");
        end
        chk("fill_level4", 64'(level), 64'd4);
        chk("fill_head0", 64'(m_araddr), 64'h0);
        p = rand_pay();
        v = 1'b1; drv = p;
        repeat (2) cycle("fill_blocked");
        rdy = 1'b1;
        push_one(p, "fill_fifth");
        for (int i = 0; i < 6; i++) cycle("fill_drain");

        // Back-to-back streaming through pointer wrap
        rdy = 1'b1;
        for (int i = 0; i < 10; i++) begin
            v = 1'b1; drv = rand_pay();
            cycle("stream");
        end
        v = 1'b0;
        repeat (2) cycle("stream_tail");

        // Downstream stall keeps head stable
        rdy = 1'b0;
        p = rand_pay(); p.addr = 32'h300; push_one(p, "stall_load");
        p = rand_pay(); p.addr = 32'h340; push_one(p, "stall_load");
        rdy = 1'b1; cycle("stall_t1");
        rdy = 1'b0; cycle("stall_t2");
        chk("stall_addr_a", 64'(m_araddr), 64'h340);
        cycle("stall_t3");
        chk("stall_addr_b", 64'(m_araddr), 64'h340);
        rdy = 1'b1; cycle("stall_t4");
        chk("stall_empty", 64'(m_arvalid), 64'd0);
        chk("stall_err_clear", 64'(err_stable), 64'd0);

        // Stability violation while full
        rdy = 1'b0;
        for (int i = 0; i < 4; i++) push_one(rand_pay(), "viol_fill");
        p = rand_pay(); p.addr = 32'h200;
        v = 1'b1; drv = p;
        cycle("viol_hold");
        drv.addr = 32'h204;
        cycle("viol_change");
        chk("viol_err_set", 64'(err_stable), 64'd1);
        cycle("viol_sticky");
        rdy = 1'b1;
        push_one(drv, "viol_accept");
        for (int i = 0; i < 6; i++) cycle("viol_drain");
        chk("viol_err_kept", 64'(err_stable), 64'd1);

        do_reset("rst_clear");

        // Random legal traffic: never changes a stalled beat
        for (int i = 0; i < 300; i++) begin
            if (!pend_m) begin
                v   = 1'($urandom_range(0, 1));
                drv = rand_pay();
            end
            rdy = 1'($urandom_range(0, 1));
            cycle("rand");
        end
        chk("rand_no_err", 64'(err_stable), 64'd0);

        // Mid-operation reset discards buffered entries
        if (pend_m) begin
            rdy = 1'b1;
            push_one(drv, "rand_finish");
        end
        v = 1'b0; rdy = 1'b1;
        for (int i = 0; i < 6; i++) cycle("pre_mid_drain");
        rdy = 1'b0;
        for (int i = 0; i < 3; i++) push_one(rand_pay(), "mid_load");
        chk("mid_level3", 64'(level), 64'd3);
        do_reset("mid_rst");
        rdy = 1'b1;
        for (int i = 0; i < 4; i++) cycle("mid_after");
        chk("mid_no_valid", 64'(m_arvalid), 64'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
